// File: rtl/regld_sched_if.sv
// Handshake bundle between thread issue, the register-load scheduler and memory.
// slave: scheduler side (requests/ready in, beats/grant/done out); master: driver side.
interface regld_sched_if #(
  parameter int NTHREADS      = 4,
  parameter int REGLD_PER_CLK = 8
);
  localparam int TW = (NTHREADS > 1) ? $clog2(NTHREADS) : 1;
  localparam int NBM = 16 / REGLD_PER_CLK;
  localparam int BW = (NBM > 1) ? $clog2(NBM) : 1;

  logic [NTHREADS-1:0] req_i;
  logic [NTHREADS-1:0] len16_i;
  logic                mem_ready_i;
  logic                mem_req_o;
  logic [TW-1:0]       mem_thread_o;
  logic [BW-1:0]       mem_beat_o;
  logic [NTHREADS-1:0] grant_o;
  logic                busy_o;
  logic [NTHREADS-1:0] done_o;

  modport slave (
    input  req_i, len16_i, mem_ready_i,
    output mem_req_o, mem_thread_o, mem_beat_o,
    output grant_o, busy_o, done_o
  );

  modport master (
    output req_i, len16_i, mem_ready_i,
    input  mem_req_o, mem_thread_o, mem_beat_o,
    input  grant_o, busy_o, done_o
  );
endinterface

// File: rtl/regld_sched.sv
// Round-robin register-load scheduler: grants one thread, issues its beats.
// Ports: clk, rst_n (sync, active-low), bus (regld_sched_if.slave).
module regld_sched #(
  parameter int NTHREADS      = 4,
  parameter int REGLD_PER_CLK = 8
) (
  input  logic clk,
  input  logic rst_n,
  regld_sched_if.slave bus
);
  localparam int TW = (NTHREADS > 1) ? $clog2(NTHREADS) : 1;
  localparam int NBM = 16 / REGLD_PER_CLK;
  localparam int BW = (NBM > 1) ? $clog2(NBM) : 1;
  localparam int NB8 = (8 / REGLD_PER_CLK > 0) ? 8 / REGLD_PER_CLK : 1;
  localparam int NB16 = (NBM > 0) ? NBM : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       ptr_q, ptr_d;
  logic [TW-1:0]       thr_q, thr_d;
  logic                len16_q, len16_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [NTHREADS-1:0] done_q, done_d;

  logic [NTHREADS-1:0] elig;
  logic                win_vld;
  logic [TW-1:0]       win;
  logic [BW-1:0]       last_beat;

  assign last_beat = len16_q ? BW'(NB16 - 1) : BW'(NB8 - 1);

  // Scan ptr+NTHREADS down to ptr+1 so the closest requester after
  // ptr is written last and wins.
  always_comb begin
    int idx;
    idx     = 0;
    elig    = bus.req_i & ~done_q;
    win_vld = 1'b0;
    win     = ptr_q;
    for (int k = NTHREADS; k >= 1; k--) begin
      idx = (int'(ptr_q) + k) % NTHREADS;
      if (elig[idx]) begin
        win_vld = 1'b1;
        win     = TW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    thr_d   = thr_q;
    len16_d = len16_q;
    beat_d  = beat_q;
    done_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = BURST;
          thr_d   = win;
          ptr_d   = win;
          len16_d = bus.len16_i[win];
          beat_d  = '0;
        end
      end
      BURST: begin
        if (bus.mem_ready_i) begin
          if (beat_q == last_beat) begin
            state_d        = IDLE;
            beat_d         = '0;
            done_d[thr_q]  = 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= TW'(NTHREADS - 1);
      thr_q   <= '0;
      len16_q <= 1'b0;
      beat_q  <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      thr_q   <= thr_d;
      len16_q <= len16_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
    end
  end

  logic busy;
  assign busy             = (state_q == BURST);
  assign bus.mem_req_o    = busy;
  assign bus.busy_o       = busy;
  assign bus.mem_thread_o = busy ? thr_q : '0;
  assign bus.mem_beat_o   = beat_q;
  assign bus.grant_o      = busy ? (NTHREADS'(1) << thr_q) : '0;
  assign bus.done_o       = done_q;
endmodule

// File: tb/tb_regld_sched.sv
// Scoreboard bench for regld_sched: reference model predicts outputs per cycle,
// monitor compares on the falling edge.
module tb_regld_sched;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regld_sched_if #(.NTHREADS(4), .REGLD_PER_CLK(8)) bus ();

  regld_sched #(.NTHREADS(4), .REGLD_PER_CLK(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       mreq;
    logic [1:0] thr;
    logic       beat;
    logic [3:0] grant;
    logic       busy;
    logic [3:0] done;
  } exp_t;

  exp_t expq[$];
  int checks = 0;
  int errors = 0;

  // reference model state
  bit       m_busy;
  int       m_owner, m_beat, m_nb, m_ptr;
  bit [3:0] m_done;

  bit       cur_rst, cur_rdy;
  bit [3:0] cur_req, cur_len;
  bit [3:0] req_v, len_v;

  task automatic step();
    bit [3:0] nd, el;
    bit got;
    int t;
    if (!cur_rst) begin
      m_busy = 0; m_beat = 0; m_done = 0; m_ptr = 3;
    end else begin
      nd = 0;
      if (m_busy) begin
        if (cur_rdy) begin
          if (m_beat == m_nb - 1) begin
            m_busy = 0; m_beat = 0; nd[m_owner] = 1;
          end else m_beat++;
        end
      end else begin
        el = cur_req & ~m_done;
        got = 0;
        for (int k = 1; k <= 4; k++) begin
          t = (m_ptr + k) % 4;
          if (el[t] && !got) begin
            got = 1; m_owner = t; m_ptr = t;
            m_nb = (cur_len[t] ? 16 : 8) / 8;
            m_beat = 0; m_busy = 1;
          end
        end
      end
      m_done = nd;
    end
  endtask

  task automatic cyc(input bit r, input bit rdy);
    exp_t e;
    @(posedge clk);
    step();
    #1;
    e.mreq  = m_busy;
    e.thr   = m_busy ? 2'(m_owner) : 2'd0;
    e.beat  = 1'(m_beat);
    e.grant = m_busy ? (4'd1 << m_owner) : 4'd0;
    e.busy  = m_busy;
    e.done  = m_done;
    expq.push_back(e);
    req_v &= ~m_done;
    cur_rst = r; cur_rdy = rdy; cur_req = req_v; cur_len = len_v;
    rst_n = r;
    bus.mem_ready_i = rdy;
    bus.len16_i = len_v;
    bus.req_i = r ? req_v : 4'bxxxx;
  endtask

  always @(negedge clk) begin
    exp_t e, a;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a = {bus.mem_req_o, bus.mem_thread_o, bus.mem_beat_o,
           bus.grant_o, bus.busy_o, bus.done_o};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got req=%b thr=%0d beat=%0d gnt=%b busy=%b done=%b want req=%b thr=%0d beat=%0d gnt=%b busy=%b done=%b",
                 $time, a.mreq, a.thr, a.beat, a.grant, a.busy, a.done,
                 e.mreq, e.thr, e.beat, e.grant, e.busy, e.done);
      end
    end
  end

  task automatic quiesce();
    req_v = 0;
    repeat (4) cyc(1, 1);
  endtask

  initial begin
    rst_n = 0; cur_rst = 0; cur_rdy = 0; cur_req = 0; cur_len = 0;
    req_v = 0; len_v = 0;
    bus.req_i = 4'bxxxx; bus.len16_i = 0; bus.mem_ready_i = 0;
    m_busy = 0; m_beat = 0; m_done = 0; m_ptr = 3; m_owner = 0; m_nb = 1;

    // reset held with all requests, thread 0 first
    req_v = 4'hF; len_v = 0;
    repeat (3) cyc(0, 1);
    repeat (10) cyc(1, 1);
    quiesce();
    // single len16 request, always ready
    req_v = 4'b0100; len_v = 4'b0100;
    repeat (5) cyc(1, 1);
    quiesce();
    // round robin 0,1,3
    req_v = 4'b1011; len_v = 0;
    repeat (8) cyc(1, 1);
    quiesce();
    // stall on beat 1
    req_v = 4'b0010; len_v = 4'b0010;
    cyc(1, 1); cyc(1, 1);
    repeat (3) cyc(1, 0);
    repeat (3) cyc(1, 1);
    quiesce();
    // reset during beat 0
    req_v = 4'b0100; len_v = 4'b0100;
    cyc(1, 1);
    cyc(0, 1);
    req_v = 4'hF; len_v = 0;
    repeat (12) cyc(1, 1);
    quiesce();
    // requester drops mid-burst
    req_v = 4'b1000; len_v = 4'b1000;
    cyc(1, 1);
    req_v = 0;
    repeat (5) cyc(1, 1);
    quiesce();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int t = 0; t < 4; t++) begin
        if (!req_v[t] && $urandom_range(3) == 0) req_v[t] = 1;
        else if (req_v[t] && $urandom_range(39) == 0) req_v[t] = 0;
      end
      len_v = 4'($urandom);
      cyc(($urandom_range(299) != 0), ($urandom_range(3) != 0));
    end
    quiesce();

    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
